// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage datapath control.
// Holds the controller state encoding, the opcode constants that decode and
// execute also use, the default drain length and a taken-transfer helper.
package pipe_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RUN      = 3'd1,
      S_STALL_LU = 3'd2,
      S_MEM_WAIT = 3'd3,
      S_FLUSH    = 3'd4,
      S_DRAIN    = 3'd5,
      S_HALT     = 3'd6
   } state_t;

   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_LD   = 5'd20;
   localparam logic [4:0] OP_ST   = 5'd21;
   localparam logic [4:0] OP_BRZ  = 5'd24;
   localparam logic [4:0] OP_JMP  = 5'd25;
   localparam logic [4:0] OP_HALT = 5'd31;

   localparam int DRAIN_CYCLES_DEF = 3;

   // Control transfer resolved in EX: unconditional jump or branch with COND set.
   function automatic logic is_taken(logic [4:0] op, logic cond);
      return (op == OP_JMP) || ((op == OP_BRZ) && cond);
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline controller and the stage registers.
// Inputs to the controller: START, ID_* decode fields, EX_* execute fields,
// MEM_BUSY. Outputs: stage enables, flush pulses, PC_SEL, ESTADO, HALTED,
// STALL_CNT. The slave modport is the controller's view, master the datapath's.
interface pipe_ctrl_if;
   logic        START;
   logic [4:0]  ID_OPCD;
   logic [4:0]  ID_RS1;
   logic [4:0]  ID_RS2;
   logic        ID_USES_RS2;
   logic [4:0]  EX_OPCD;
   logic [4:0]  EX_ADDR_REG;
   logic        EX_COND;
   logic        MEM_BUSY;

   logic        PC_EN;
   logic        IFID_EN;
   logic        IDEX_EN;
   logic        EXMEM_EN;
   logic        MEMWB_EN;
   logic        IFID_FLUSH;
   logic        IDEX_FLUSH;
   logic        PC_SEL;
   logic [2:0]  ESTADO;
   logic        HALTED;
   logic [15:0] STALL_CNT;

   modport slave (
      input  START, ID_OPCD, ID_RS1, ID_RS2, ID_USES_RS2,
             EX_OPCD, EX_ADDR_REG, EX_COND, MEM_BUSY,
      output PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN,
             IFID_FLUSH, IDEX_FLUSH, PC_SEL, ESTADO, HALTED, STALL_CNT
   );

   modport master (
      output START, ID_OPCD, ID_RS1, ID_RS2, ID_USES_RS2,
             EX_OPCD, EX_ADDR_REG, EX_COND, MEM_BUSY,
      input  PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN,
             IFID_FLUSH, IDEX_FLUSH, PC_SEL, ESTADO, HALTED, STALL_CNT
   );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator.
// ex_opcd/ex_addr_reg: instruction in EX; id_rs1/id_rs2/id_uses_rs2: sources
// of the instruction in ID. load_use is high when ID needs a value that the
// load in EX has not produced yet. r0 is hardwired, so it never creates a hazard.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [4:0] ex_opcd,
   input  logic [4:0] ex_addr_reg,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs2,
   output logic       load_use
);
   assign load_use = (ex_opcd == OP_LD) && (ex_addr_reg != 5'd0) &&
                     ((id_rs1 == ex_addr_reg) ||
                      (id_uses_rs2 && (id_rs2 == ex_addr_reg)));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing and hazard controller for the five-stage datapath.
// Ports: CLK (rising edge), RST (synchronous, active high), bus (pipe_ctrl_if
// slave: hazard inputs in; stage enables, flushes, PC_SEL, ESTADO, HALTED,
// STALL_CNT out). Control outputs are Mealy; ESTADO, HALTED and STALL_CNT are
// registered. DRAIN_CYCLES sets how long the pipe drains after HALT leaves ID.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
)(
   input  logic        CLK,
   input  logic        RST,
   pipe_ctrl_if.slave  bus
);

   state_t      state, nxt;
   logic        halted;
   logic [15:0] stall_cnt;
   logic [15:0] drain_cnt;

   logic        load_use;
   logic        taken;
   logic [4:0]  en;          // {pc, ifid, idex, exmem, memwb}
   logic        ifid_flush, idex_flush, pc_sel;
   logic        stall_ev;    // load-use bubble or memory freeze this cycle
   logic        drain_load;

   hazard_detect u_hz (
      .ex_opcd     (bus.EX_OPCD),
      .ex_addr_reg (bus.EX_ADDR_REG),
      .id_rs1      (bus.ID_RS1),
      .id_rs2      (bus.ID_RS2),
      .id_uses_rs2 (bus.ID_USES_RS2),
      .load_use    (load_use)
   );

   assign taken = is_taken(bus.EX_OPCD, bus.EX_COND);

   always_comb begin
      nxt        = state;
      en         = 5'b00000;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      pc_sel     = 1'b0;
      stall_ev   = 1'b0;
      drain_load = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.START) nxt = S_RUN;
         end
         // MEM_WAIT shares the RUN decision: a held MEM_BUSY simply re-selects
         // the freeze. FLUSH ignores load-use and HALT since ID holds a bubble.
         S_RUN, S_STALL_LU, S_MEM_WAIT, S_FLUSH: begin
            if (bus.MEM_BUSY) begin
               stall_ev = 1'b1;
               nxt      = S_MEM_WAIT;
            end else if (taken) begin
               en         = 5'b11111;
               pc_sel     = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               nxt        = S_FLUSH;
            end else if (state != S_FLUSH && load_use) begin
               // Hold PC and IF/ID, load a bubble into ID/EX, let the load finish.
               en         = 5'b00111;
               idex_flush = 1'b1;
               stall_ev   = 1'b1;
               nxt        = S_STALL_LU;
            end else if (state != S_FLUSH && bus.ID_OPCD == OP_HALT) begin
               en         = 5'b01111;
               ifid_flush = 1'b1;
               drain_load = 1'b1;
               nxt        = S_DRAIN;
            end else begin
               en  = 5'b11111;
               nxt = S_RUN;
            end
         end
         S_DRAIN: begin
            if (bus.MEM_BUSY) begin
               stall_ev = 1'b1;
            end else begin
               en = 5'b00111;
               if (drain_cnt == 16'd0) nxt = S_HALT;
            end
         end
         S_HALT: ;
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         halted    <= 1'b0;
         stall_cnt <= 16'd0;
         drain_cnt <= 16'd0;
      end else begin
         state  <= nxt;
         halted <= (nxt == S_HALT);
         if (stall_ev && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (drain_load)
            drain_cnt <= 16'(DRAIN_CYCLES);
         else if (state == S_DRAIN && !bus.MEM_BUSY && drain_cnt != 16'd0)
            drain_cnt <= drain_cnt - 16'd1;
      end
   end

   assign bus.PC_EN      = en[4];
   assign bus.IFID_EN    = en[3];
   assign bus.IDEX_EN    = en[2];
   assign bus.EXMEM_EN   = en[1];
   assign bus.MEMWB_EN   = en[0];
   assign bus.IFID_FLUSH = ifid_flush;
   assign bus.IDEX_FLUSH = idex_flush;
   assign bus.PC_SEL     = pc_sel;
   assign bus.ESTADO     = state;
   assign bus.HALTED     = halted;
   assign bus.STALL_CNT  = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a vector table applied from RUN, plus
// hand sequences for reset, memory wait, FLUSH masking, HALT drain and
// STALL_CNT saturation. Mealy outputs are checked before the edge; the
// registered state/HALTED/STALL_CNT expectations go through a scoreboard queue.
module tb_pipe_ctrl;
   import pipe_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   pipe_ctrl_if bus();

   pipe_ctrl #(.DRAIN_CYCLES(3)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   // ctl = {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN, IFID_FLUSH, IDEX_FLUSH, PC_SEL}
   localparam logic [7:0] ADV = 8'b11111_000;
   localparam logic [7:0] FRZ = 8'b00000_000;
   localparam logic [7:0] LU  = 8'b00111_010;
   localparam logic [7:0] BR  = 8'b11111_111;
   localparam logic [7:0] HLT = 8'b01111_100;
   localparam logic [7:0] DRN = 8'b00111_000;

   typedef struct {
      string      name;
      logic [4:0] idop, rs1, rs2;
      logic       uses;
      logic [4:0] exop, exaddr;
      logic       cond, busy;
      logic [7:0] ctl;
      state_t     st;
      logic       inc;
   } vec_t;

   typedef struct {
      string       name;
      logic [2:0]  st;
      logic        halted;
      logic [15:0] scnt;
   } exp_t;

   vec_t        tv[13];
   exp_t        sbq[$];
   exp_t        e;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [15:0] exp_scnt = 16'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drv(input logic [4:0] idop, rs1, rs2, input logic uses,
                      input logic [4:0] exop, exaddr, input logic cond, busy, start);
      bus.ID_OPCD = idop;  bus.ID_RS1 = rs1;  bus.ID_RS2 = rs2;
      bus.ID_USES_RS2 = uses;
      bus.EX_OPCD = exop;  bus.EX_ADDR_REG = exaddr;
      bus.EX_COND = cond;  bus.MEM_BUSY = busy;  bus.START = start;
   endtask

   task automatic nop();
      drv(OP_NOP, 5'd0, 5'd0, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [7:0] ctl_now();
      return {bus.PC_EN, bus.IFID_EN, bus.IDEX_EN, bus.EXMEM_EN, bus.MEMWB_EN,
              bus.IFID_FLUSH, bus.IDEX_FLUSH, bus.PC_SEL};
   endfunction

   // One cycle: check Mealy outputs, queue the post-edge expectation, take the edge.
   task automatic cyc(input string name, input logic [7:0] ctl, input state_t st,
                      input logic halted, input logic inc);
      exp_t x;
      #1;
      chk({name, "/ctl"}, {24'd0, ctl_now()}, {24'd0, ctl});
      if (inc && exp_scnt != 16'hFFFF) exp_scnt = exp_scnt + 16'd1;
      x.name = {name, "/reg"}; x.st = st; x.halted = halted; x.scnt = exp_scnt;
      sbq.push_back(x);
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic reg_chk(input string name, input state_t st, input logic halted,
                          input logic [15:0] scnt);
      chk(name, {12'd0, bus.ESTADO, bus.HALTED, bus.STALL_CNT}, {12'd0, st, halted, scnt});
   endtask

   task automatic do_reset();
      RST = 1'b1;
      nop();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      exp_scnt = 16'd0;
      reg_chk("reset/reg", S_IDLE, 1'b0, 16'd0);
      #1 chk("reset/ctl", {24'd0, ctl_now()}, 32'd0);
   endtask

   task automatic start_run();
      nop(); bus.START = 1'b1;
      cyc("start", FRZ, S_RUN, 1'b0, 1'b0);
      nop();
   endtask

   task automatic setv(input int i, input string n, input logic [4:0] idop, rs1, rs2,
                       input logic uses, input logic [4:0] exop, exaddr,
                       input logic cond, busy, input logic [7:0] ctl,
                       input state_t st, input logic inc);
      tv[i].name = n; tv[i].idop = idop; tv[i].rs1 = rs1; tv[i].rs2 = rs2;
      tv[i].uses = uses; tv[i].exop = exop; tv[i].exaddr = exaddr;
      tv[i].cond = cond; tv[i].busy = busy; tv[i].ctl = ctl; tv[i].st = st;
      tv[i].inc = inc;
   endtask

   // Registered outputs are compared as the DUT produces them after each edge.
   always begin
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk(e.name, {12'd0, bus.ESTADO, bus.HALTED, bus.STALL_CNT},
             {12'd0, e.st, e.halted, e.scnt});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //       name         idop     rs1 rs2 us exop    exad c  b  ctl  next        inc
      setv(0,  "nop",       OP_NOP,  1,  2,  1, OP_NOP, 0,   0, 0, ADV, S_RUN,      0);
      setv(1,  "lu_rs1",    OP_NOP,  5,  2,  0, OP_LD,  5,   0, 0, LU,  S_STALL_LU, 1);
      setv(2,  "lu_rs2",    OP_NOP,  1,  7,  1, OP_LD,  7,   0, 0, LU,  S_STALL_LU, 1);
      setv(3,  "rs2_unused",OP_NOP,  1,  7,  0, OP_LD,  7,   0, 0, ADV, S_RUN,      0);
      setv(4,  "lu_r0",     OP_NOP,  0,  0,  1, OP_LD,  0,   0, 0, ADV, S_RUN,      0);
      setv(5,  "brz_taken", OP_NOP,  1,  2,  0, OP_BRZ, 0,   1, 0, BR,  S_FLUSH,    0);
      setv(6,  "brz_not",   OP_NOP,  1,  2,  0, OP_BRZ, 0,   0, 0, ADV, S_RUN,      0);
      setv(7,  "jmp",       OP_NOP,  1,  2,  0, OP_JMP, 0,   0, 0, BR,  S_FLUSH,    0);
      setv(8,  "busy",      OP_NOP,  1,  2,  0, OP_NOP, 0,   0, 1, FRZ, S_MEM_WAIT, 1);
      setv(9,  "busy_lu",   OP_NOP,  5,  2,  0, OP_LD,  5,   0, 1, FRZ, S_MEM_WAIT, 1);
      setv(10, "jmp_halt",  OP_HALT, 1,  2,  0, OP_JMP, 0,   0, 0, BR,  S_FLUSH,    0);
      setv(11, "jmp_lu",    OP_NOP,  5,  2,  0, OP_JMP, 5,   0, 0, BR,  S_FLUSH,    0);
      setv(12, "st_no_lu",  OP_NOP,  5,  2,  0, OP_ST,  5,   0, 0, ADV, S_RUN,      0);

      nop();
      @(negedge CLK);
      do_reset();
      start_run();
      cyc("run_adv", ADV, S_RUN, 1'b0, 1'b0);

      for (int i = 0; i < 13; i++) begin
         drv(tv[i].idop, tv[i].rs1, tv[i].rs2, tv[i].uses, tv[i].exop,
             tv[i].exaddr, tv[i].cond, tv[i].busy, 1'b0);
         cyc(tv[i].name, tv[i].ctl, tv[i].st, 1'b0, tv[i].inc);
         nop();
         cyc({tv[i].name, "_rec"}, ADV, S_RUN, 1'b0, 1'b0);
      end

      // FLUSH holds a bubble in ID: load-use and HALT are ignored, branches are not.
      drv(OP_NOP, 0, 0, 0, OP_JMP, 0, 0, 0, 0);  cyc("fl_enter1", BR, S_FLUSH, 0, 0);
      drv(OP_NOP, 5, 0, 0, OP_LD, 5, 0, 0, 0);   cyc("fl_lu_mask", ADV, S_RUN, 0, 0);
      drv(OP_NOP, 0, 0, 0, OP_JMP, 0, 0, 0, 0);  cyc("fl_enter2", BR, S_FLUSH, 0, 0);
      drv(OP_HALT, 0, 0, 0, OP_NOP, 0, 0, 0, 0); cyc("fl_halt_mask", ADV, S_RUN, 0, 0);
      drv(OP_NOP, 0, 0, 0, OP_JMP, 0, 0, 0, 0);  cyc("fl_enter3", BR, S_FLUSH, 0, 0);
      drv(OP_NOP, 0, 0, 0, OP_BRZ, 0, 1, 0, 0);  cyc("fl_brz", BR, S_FLUSH, 0, 0);
      nop();                                     cyc("fl_exit", ADV, S_RUN, 0, 0);

      // Three-cycle memory wait with a pending load-use, re-evaluated after the wait.
      drv(OP_NOP, 3, 0, 0, OP_LD, 3, 0, 1, 0);
      cyc("mw1", FRZ, S_MEM_WAIT, 0, 1);
      cyc("mw2", FRZ, S_MEM_WAIT, 0, 1);
      cyc("mw3", FRZ, S_MEM_WAIT, 0, 1);
      bus.MEM_BUSY = 1'b0;
      cyc("mw_lu", LU, S_STALL_LU, 0, 1);
      nop();
      cyc("mw_resume", ADV, S_RUN, 0, 0);

      // HALT drain: DRAIN_CYCLES+2 non-busy edges from HALT in ID to HALTED.
      do_reset();
      start_run();
      drv(OP_HALT, 0, 0, 0, OP_NOP, 0, 0, 0, 0); cyc("halt_id", HLT, S_DRAIN, 0, 0);
      nop();
      cyc("drain1", DRN, S_DRAIN, 0, 0);
      bus.MEM_BUSY = 1'b1;
      cyc("drain_busy", FRZ, S_DRAIN, 0, 1);
      bus.MEM_BUSY = 1'b0;
      cyc("drain2", DRN, S_DRAIN, 0, 0);
      cyc("drain3", DRN, S_DRAIN, 0, 0);
      cyc("drain4", DRN, S_HALT, 1, 0);
      bus.START = 1'b1;
      cyc("halt_start", FRZ, S_HALT, 1, 0);
      nop();
      cyc("halt_hold", FRZ, S_HALT, 1, 0);
      do_reset();

      // Reset in the middle of DRAIN.
      start_run();
      drv(OP_HALT, 0, 0, 0, OP_NOP, 0, 0, 0, 0); cyc("halt_id2", HLT, S_DRAIN, 0, 0);
      nop();
      cyc("drain_b", DRN, S_DRAIN, 0, 0);
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      exp_scnt = 16'd0;
      reg_chk("rst_in_drain", S_IDLE, 1'b0, 16'd0);

      // STALL_CNT saturation under a long memory freeze.
      do_reset();
      start_run();
      bus.MEM_BUSY = 1'b1;
      repeat (65540) @(posedge CLK);
      @(negedge CLK);
      reg_chk("stall_sat", S_MEM_WAIT, 1'b0, 16'hFFFF);
      nop();

      @(posedge CLK);
      @(negedge CLK);
      chk("sb_drained", sbq.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
